// File: rtl/ara_eoc_if.sv
// Snooped memory write-path request bus; the monitor only ever observes it via the slave modport.
interface ara_eoc_if #(
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64
);
  logic                   req_valid;
  logic                   req_ready;
  logic                   req_we;
  logic [AddrWidth-1:0]   req_addr;
  logic [DataWidth-1:0]   req_wdata;
  logic [DataWidth/8-1:0] req_be;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready
  );

  modport slave (
    input req_valid, req_ready, req_we, req_addr, req_wdata, req_be
  );
endinterface

// File: rtl/ara_eoc_monitor.sv
// End-of-computation snoop: latches the tohost exit word and times the vector runtime window.
// Registered outputs, one cycle after the firing edge; ARA_EOC_WATCHDOG_EN adds a timeout that forces exit.
module ara_eoc_monitor #(
  parameter int unsigned AddrWidth     = 64,
  parameter int unsigned DataWidth     = 64,
  parameter logic [63:0] ToHostAddr    = 64'h0000_0000_8000_1000,
  parameter logic [63:0] TimerAddr     = 64'h0000_0000_8000_1008,
  parameter logic [63:0] TimeoutCycles = 64'd10_000_000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  ara_eoc_if.slave    req,
  output logic [63:0] exit_o,
  output logic [63:0] runtime_o,
  output logic        runtime_valid_o,
  output logic        timing_o
);

  typedef enum logic [1:0] {IDLE, TIMING, DONE} state_e;

  localparam logic [63:0] AllOnes = '1;

  state_e      state_q, state_d;
  logic [63:0] cnt_q, cnt_d;
  logic [63:0] staging_q, staging_d;
  logic [63:0] exit_q, exit_d;
  logic [63:0] runtime_q, runtime_d;
  logic        runtime_valid_q, runtime_valid_d;
  logic        timing_q, timing_d;

  logic        fire, hit_tohost, hit_timer;
  logic [63:0] lane_data;
  logic [7:0]  lane_be;
  logic [63:0] tohost_merged, timer_bytes, cnt_inc;
  logic        timer_nz, done_store, wd_expire;
  logic [63:0] wd_exit;
  logic        unused_addr_lsbs;

  assign fire       = req.req_valid & req.req_ready & req.req_we;
  assign hit_tohost = fire && (req.req_addr[AddrWidth-1:3] == ToHostAddr[AddrWidth-1:3]);
  assign hit_timer  = fire && (req.req_addr[AddrWidth-1:3] == TimerAddr[AddrWidth-1:3]);
  assign unused_addr_lsbs = ^req.req_addr[2:0];

  generate
    if (DataWidth == 64) begin : g_single_lane
      assign lane_data = req.req_wdata;
      assign lane_be   = req.req_be;
    end else begin : g_multi_lane
      localparam int unsigned LaneIdxW = $clog2(DataWidth / 64);
      logic [LaneIdxW-1:0] lane_idx;
      assign lane_idx  = req.req_addr[LaneIdxW+2:3];
      assign lane_data = req.req_wdata[lane_idx*64 +: 64];
      assign lane_be   = req.req_be[lane_idx*8 +: 8];
    end
  endgenerate

  // Tohost merges into staging; the timer value only sees strobed bytes.
  always_comb begin
    tohost_merged = staging_q;
    timer_bytes   = '0;
    for (int i = 0; i < 8; i++) begin
      if (lane_be[i]) begin
        tohost_merged[i*8 +: 8] = lane_data[i*8 +: 8];
        timer_bytes[i*8 +: 8]   = lane_data[i*8 +: 8];
      end
    end
  end

  assign timer_nz   = |timer_bytes;
  assign done_store = hit_tohost & tohost_merged[0];
  assign cnt_inc    = (cnt_q == AllOnes) ? cnt_q : cnt_q + 64'd1;

`ifdef ARA_EOC_WATCHDOG_EN
  logic [63:0] wd_cnt_q, wd_cnt_d;
  assign wd_cnt_d  = (wd_cnt_q == AllOnes) ? wd_cnt_q : wd_cnt_q + 64'd1;
  assign wd_expire = (wd_cnt_q >= TimeoutCycles);
  assign wd_exit   = {63'h7FFF_DEAD, 1'b1};
`else
  logic [63:0] unused_timeout;
  assign unused_timeout = TimeoutCycles;
  assign wd_expire      = 1'b0;
  assign wd_exit        = '0;
`endif

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    staging_d       = staging_q;
    exit_d          = exit_q;
    runtime_d       = runtime_q;
    runtime_valid_d = runtime_valid_q;
    if (state_q != DONE) begin
      if (hit_tohost) staging_d = tohost_merged;
      if (state_q == TIMING) cnt_d = cnt_inc;
      // A done store wins over a watchdog expiry in the same cycle.
      if (done_store || wd_expire) begin
        state_d = DONE;
        exit_d  = done_store ? tohost_merged : wd_exit;
        if (state_q == TIMING) begin
          runtime_d       = cnt_inc;
          runtime_valid_d = 1'b1;
        end
      end else if (hit_timer && timer_nz) begin
        state_d = TIMING;
        cnt_d   = '0;
        if (state_q == IDLE) runtime_valid_d = 1'b0;
      end else if (hit_timer && state_q == TIMING) begin
        state_d         = IDLE;
        runtime_d       = cnt_inc;
        runtime_valid_d = 1'b1;
      end
    end
    timing_d = (state_d == TIMING);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      staging_q       <= '0;
      exit_q          <= '0;
      runtime_q       <= '0;
      runtime_valid_q <= 1'b0;
      timing_q        <= 1'b0;
`ifdef ARA_EOC_WATCHDOG_EN
      wd_cnt_q        <= '0;
`endif
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      staging_q       <= staging_d;
      exit_q          <= exit_d;
      runtime_q       <= runtime_d;
      runtime_valid_q <= runtime_valid_d;
      timing_q        <= timing_d;
`ifdef ARA_EOC_WATCHDOG_EN
      wd_cnt_q        <= wd_cnt_d;
`endif
    end
  end

  assign exit_o          = exit_q;
  assign runtime_o       = runtime_q;
  assign runtime_valid_o = runtime_valid_q;
  assign timing_o        = timing_q;

endmodule

// File: tb/tb_ara_eoc_monitor.sv
// Directed bench for ara_eoc_monitor: a 64-bit and a 256-bit instance share clock and reset.
module tb_ara_eoc_monitor;

  localparam logic [63:0] TOHOST = 64'h0000_0000_8000_1000;
  localparam logic [63:0] TIMER  = 64'h0000_0000_8000_1008;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  ara_eoc_if #(.AddrWidth(64), .DataWidth(64))  bus ();
  ara_eoc_if #(.AddrWidth(64), .DataWidth(256)) busw ();

  logic [63:0] exit_o, runtime_o, exit_w, runtime_w;
  logic        runtime_valid_o, timing_o, runtime_valid_w, timing_w;

  ara_eoc_monitor #(.AddrWidth(64), .DataWidth(64)) u_dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .req             (bus),
    .exit_o          (exit_o),
    .runtime_o       (runtime_o),
    .runtime_valid_o (runtime_valid_o),
    .timing_o        (timing_o)
  );

  ara_eoc_monitor #(.AddrWidth(64), .DataWidth(256)) u_dut_w (
    .clk_i           (clk),
    .rst_i           (rst),
    .req             (busw),
    .exit_o          (exit_w),
    .runtime_o       (runtime_w),
    .runtime_valid_o (runtime_valid_w),
    .timing_o        (timing_w)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [63:0] a, input logic [63:0] d, input logic [7:0] b,
                    input logic rdy, input logic we);
    bus.req_valid = 1'b1;
    bus.req_ready = rdy;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_be    = b;
    tick();
    bus.req_valid = 1'b0;
    bus.req_ready = 1'b1;
    bus.req_we    = 1'b0;
  endtask

  task automatic wr_w(input logic [63:0] a, input logic [255:0] d, input logic [31:0] b);
    busw.req_valid = 1'b1;
    busw.req_we    = 1'b1;
    busw.req_addr  = a;
    busw.req_wdata = d;
    busw.req_be    = b;
    tick();
    busw.req_valid = 1'b0;
    busw.req_we    = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    clk   = 1'b0;
    rst   = 1'b1;
    bus.req_valid  = 1'b0; bus.req_ready  = 1'b1; bus.req_we  = 1'b0;
    bus.req_addr   = '0;   bus.req_wdata  = '0;   bus.req_be  = '0;
    busw.req_valid = 1'b0; busw.req_ready = 1'b1; busw.req_we = 1'b0;
    busw.req_addr  = '0;   busw.req_wdata = '0;   busw.req_be = '0;

    idle(2);
    rst = 1'b0;
    idle(5);
    chk_eq("rst_exit", exit_o, 64'h0);
    chk_eq("rst_runtime", runtime_o, 64'h0);
    chk_eq("rst_rvalid", {63'h0, runtime_valid_o}, 64'h0);
    chk_eq("rst_timing", {63'h0, timing_o}, 64'h0);
    chk_eq("rst_exit_w", exit_w, 64'h0);

    // Non-firing requests and a zero store in IDLE change nothing.
    wr(TIMER, 64'h1, 8'hFF, 1'b0, 1'b1);
    chk_eq("noready_timing", {63'h0, timing_o}, 64'h0);
    wr(TIMER, 64'h1, 8'hFF, 1'b1, 1'b0);
    chk_eq("read_timing", {63'h0, timing_o}, 64'h0);
    wr(TIMER, 64'h0, 8'hFF, 1'b1, 1'b1);
    chk_eq("idle_zero_timing", {63'h0, timing_o}, 64'h0);
    chk_eq("idle_zero_rvalid", {63'h0, runtime_valid_o}, 64'h0);

    // Start, 99 idle cycles, stop on the 100th edge.
    wr(TIMER, 64'h1, 8'hFF, 1'b1, 1'b1);
    chk_eq("start_timing", {63'h0, timing_o}, 64'h1);
    idle(99);
    chk_eq("mid_timing", {63'h0, timing_o}, 64'h1);
    chk_eq("mid_rvalid", {63'h0, runtime_valid_o}, 64'h0);
    wr(TIMER, 64'h0, 8'hFF, 1'b1, 1'b1);
    chk_eq("stop_runtime", runtime_o, 64'd100);
    chk_eq("stop_rvalid", {63'h0, runtime_valid_o}, 64'h1);
    chk_eq("stop_timing", {63'h0, timing_o}, 64'h0);

    // Strobe-filtered start, restart, then stop with only a zero byte strobed.
    wr(TIMER, 64'h5, 8'h01, 1'b1, 1'b1);
    chk_eq("start2_timing", {63'h0, timing_o}, 64'h1);
    chk_eq("start2_rvalid_clr", {63'h0, runtime_valid_o}, 64'h0);
    idle(20);
    wr(TIMER, 64'h100, 8'h02, 1'b1, 1'b1);
    idle(4);
    wr(TIMER, 64'hFF00, 8'h01, 1'b1, 1'b1);
    chk_eq("restart_runtime", runtime_o, 64'd5);
    chk_eq("restart_rvalid", {63'h0, runtime_valid_o}, 64'h1);
    wr(TIMER, 64'h1, 8'h00, 1'b1, 1'b1);
    chk_eq("nostrobe_timing", {63'h0, timing_o}, 64'h0);

    // Tohost: miss, not-done store, done store, ignored follow-ups.
    wr(TOHOST + 64'd16, 64'h1, 8'hFF, 1'b1, 1'b1);
    chk_eq("miss_exit", exit_o, 64'h0);
    wr(TOHOST, 64'h2, 8'hFF, 1'b1, 1'b1);
    chk_eq("notdone_exit", exit_o, 64'h0);
    wr(TOHOST, 64'h1, 8'hFF, 1'b1, 1'b1);
    chk_eq("done_exit", exit_o, 64'h1);
    wr(TOHOST, 64'h7, 8'hFF, 1'b1, 1'b1);
    chk_eq("done_frozen_exit", exit_o, 64'h1);
    wr(TIMER, 64'h1, 8'hFF, 1'b1, 1'b1);
    chk_eq("done_timer_ignored", {63'h0, timing_o}, 64'h0);

    // Reset mid-run discards the latched exit word.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk_eq("rerst_exit", exit_o, 64'h0);
    chk_eq("rerst_runtime", runtime_o, 64'h0);
    chk_eq("rerst_rvalid", {63'h0, runtime_valid_o}, 64'h0);

    // Tohost done while timing latches the runtime.
    wr(TIMER, 64'h1, 8'hFF, 1'b1, 1'b1);
    idle(39);
    wr(TOHOST, 64'h3, 8'hFF, 1'b1, 1'b1);
    chk_eq("tt_exit", exit_o, 64'h3);
    chk_eq("tt_runtime", runtime_o, 64'd40);
    chk_eq("tt_rvalid", {63'h0, runtime_valid_o}, 64'h1);
    chk_eq("tt_timing", {63'h0, timing_o}, 64'h0);
    wr(TIMER, 64'h1, 8'hFF, 1'b1, 1'b1);
    chk_eq("tt_after_timing", {63'h0, timing_o}, 64'h0);
    chk_eq("tt_after_runtime", runtime_o, 64'd40);

    // Wide bus: timer lives in lane 1; lane 0 carries decoy non-zero data.
    wr_w(TIMER, {64'h0, 64'h0, 64'h1, 64'hFFFF}, {8'h00, 8'h00, 8'hFF, 8'hFF});
    chk_eq("w_start_timing", {63'h0, timing_w}, 64'h1);
    idle(9);
    wr_w(TIMER, {64'h0, 64'h0, 64'h0, 64'hFFFF}, {8'hFF, 8'hFF, 8'hFF, 8'hFF});
    chk_eq("w_stop_runtime", runtime_w, 64'd10);
    chk_eq("w_stop_rvalid", {63'h0, runtime_valid_w}, 64'h1);

    // Wide tohost in lane 0, upper lanes carry decoy done-bit data.
    wr_w(TOHOST, {{3{64'hFFFF_FFFF_FFFF_FFFF}}, 64'h0}, 32'hFFFF_FFFF);
    chk_eq("w_zero_exit", exit_w, 64'h0);
    wr_w(TOHOST, {{3{64'hFFFF_FFFF_FFFF_FFFF}}, 64'h0000_0001_5555_5555}, 32'hFFFF_FFF0);
    chk_eq("w_high_exit", exit_w, 64'h0);
    wr_w(TOHOST, {{3{64'hFFFF_FFFF_FFFF_FFFF}}, 64'hAAAA_AAAA_0000_0007}, 32'hFFFF_FF0F);
    chk_eq("w_low_exit", exit_w, 64'h0000_0001_0000_0007);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
